// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: pops the async FIFO read side and re-presents words as a
// valid/ready stream through a 2-entry skid buffer, 1 word/cycle when unstalled.
module fifo_rd_stream_adapter #(
   parameter int DSIZE = 8,
   parameter int CNTW  = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             m_valid,
   output logic [DSIZE-1:0] m_data,
   input  logic             m_ready,
   output logic [CNTW-1:0]  pop_cnt,
   output logic             ovf_err
);
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   logic [1:0]       cnt;
   logic             inflight;
   logic [DSIZE-1:0] tail;
   logic             take;
   logic             cap;
   logic             ovf;
   logic [2:0]       occ;
   assign take    = m_valid && m_ready;
   // occupancy once this cycle's take and the in-flight word are accounted for
   assign occ     = {1'b0, cnt} + {2'b0, inflight} - {2'b0, take};
   assign rinc    = !rempty && rrst_n && (occ < 3'd2);
   assign m_valid = (cnt != EMPTY);
   assign ovf     = inflight && (cnt == FULL) && !take;
   assign cap     = inflight && !ovf;
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         cnt      <= EMPTY;
         inflight <= 1'b0;
         m_data   <= '0;
         tail     <= '0;
         pop_cnt  <= '0;
         ovf_err  <= 1'b0;
      end else begin
         inflight <= rinc;
         pop_cnt  <= pop_cnt + CNTW'(rinc);
         if (ovf) ovf_err <= 1'b1;
         cnt <= cnt - {1'b0, take} + {1'b0, cap};
         // head is refilled directly when the arriving word has nobody ahead of it
         if (cap && ((cnt == EMPTY) || ((cnt == ONE) && take))) m_data <= rdata;
         else if (take && (cnt == FULL)) m_data <= tail;
         if (cap && (((cnt == ONE) && !take) || (cnt == FULL))) tail <= rdata;
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: FIFO read-side model plus scoreboard of words pushed
// into the FIFO, compared against the stream beats the adapter produces.
module tb_fifo_rd_stream_adapter;
   localparam int DSIZE = 8;
   localparam int CNTW  = 16;
   logic             rclk = 1'b0;
   logic             rrst_n = 1'b0;
   logic             rempty = 1'b1;
   logic [DSIZE-1:0] rdata = '0;
   logic             rinc;
   logic             m_valid;
   logic [DSIZE-1:0] m_data;
   logic             m_ready = 1'b0;
   logic [CNTW-1:0]  pop_cnt;
   logic             ovf_err;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [DSIZE-1:0] fifo_q[$];
   logic [DSIZE-1:0] exp_q[$];
   int rinc_cyc[$];
   int take_cyc[$];
   logic prev_stall = 1'b0;
   logic [DSIZE-1:0] prev_data = '0;

   always #5 rclk = ~rclk;

   fifo_rd_stream_adapter #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .pop_cnt(pop_cnt),
      .ovf_err(ovf_err)
   );

   // FIFO model: registered read data, empty flag tracks the queue
   always @(posedge rclk) begin
      if (rinc) begin
         total++;
         if (rempty || fifo_q.size() == 0) begin
            bad++;
            $display("FAIL rinc_while_empty rinc=1 rempty=%0b required rinc=0", rempty);
         end else rdata <= fifo_q.pop_front();
         rinc_cyc.push_back(cyc);
      end
      cyc = cyc + 1;
      #1 rempty = (fifo_q.size() == 0);
   end

   always @(negedge rclk) begin : mon
      logic [DSIZE-1:0] e;
      if (rrst_n) begin
         if (prev_stall) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               bad++;
               $display("FAIL hold got valid=%0b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
            end
         end
         if (m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_beat got data=%h required no beat", m_data);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e) begin
                  bad++;
                  $display("FAIL order got data=%h required %h", m_data, e);
               end
            end
            take_cyc.push_back(cyc);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end else prev_stall = 1'b0;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge rclk);
      #2;
   endtask

   task automatic push(input logic [DSIZE-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      rempty = 1'b0;
   endtask

   task automatic release_reset();
      int k;
      k = exp_q.size() - fifo_q.size();
      repeat (k) void'(exp_q.pop_front());
      rinc_cyc.delete();
      take_cyc.delete();
      @(negedge rclk);
      @(negedge rclk);
      rrst_n = 1'b1;
      tick(1);
   endtask

   task automatic reset_all();
      rrst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      rempty = 1'b1;
      m_ready = 1'b0;
      release_reset();
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      while (exp_q.size() > 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      ok = (exp_q.size() == 0);
   endtask

   task automatic test_reset();
      push(8'h77);
      tick(3);
      rrst_n = 1'b0;
      #1;
      total++;
      if ({rinc, m_valid, m_data, pop_cnt, ovf_err} !== '0) begin
         bad++;
         $display("FAIL reset got rinc=%0b valid=%0b data=%h pop=%0d ovf=%0b required all 0", rinc, m_valid, m_data, pop_cnt, ovf_err);
      end
      fifo_q.delete();
      exp_q.delete();
      rempty = 1'b1;
      release_reset();
   endtask

   task automatic test_stream();
      bit ok;
      reset_all();
      m_ready = 1'b1;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      tick(10);
      total++;
      ok = (rinc_cyc.size() == 3) && (rinc_cyc[1] == rinc_cyc[0] + 1) && (rinc_cyc[2] == rinc_cyc[0] + 2);
      if (!ok) begin
         bad++;
         $display("FAIL stream_rinc got pops=%0d required 3 consecutive", rinc_cyc.size());
      end
      total++;
      ok = ok && (take_cyc.size() == 3);
      for (int i = 0; ok && i < 3; i++) ok = (take_cyc[i] == rinc_cyc[0] + 2 + i);
      if (!ok) begin
         bad++;
         $display("FAIL stream_latency got beats=%0d required 3 beats at first_rinc+2..+4", take_cyc.size());
      end
      total++;
      if (pop_cnt !== 16'd3) begin
         bad++;
         $display("FAIL stream_pop_cnt got=%0d required=3", pop_cnt);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      reset_all();
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      tick(10);
      total++;
      if (pop_cnt !== 16'd2 || rinc !== 1'b0) begin
         bad++;
         $display("FAIL bp_pops got pop=%0d rinc=%0b required pop=2 rinc=0", pop_cnt, rinc);
      end
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
         bad++;
         $display("FAIL bp_head got valid=%0b data=%h required valid=1 data=a0", m_valid, m_data);
      end
      m_ready = 1'b1;
      wait_drain(20, ok);
      total++;
      if (!ok || pop_cnt !== 16'd4) begin
         bad++;
         $display("FAIL bp_drain got left=%0d pop=%0d required left=0 pop=4", exp_q.size(), pop_cnt);
      end
   endtask

   task automatic test_empty();
      int vbad;
      reset_all();
      vbad = 0;
      for (int i = 0; i < 20; i++) begin
         m_ready = i[0];
         tick(1);
         if (m_valid !== 1'b0) vbad++;
      end
      total++;
      if (vbad != 0 || rinc_cyc.size() != 0 || pop_cnt !== '0) begin
         bad++;
         $display("FAIL empty got valid_cycles=%0d pops=%0d pop_cnt=%0d required 0 0 0", vbad, rinc_cyc.size(), pop_cnt);
      end
   endtask

   task automatic test_bursts();
      int r0;
      int t0;
      reset_all();
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r0 = rinc_cyc.size();
         t0 = take_cyc.size();
         push(8'h50 + 8'(i));
         tick(6);
         total++;
         if (rinc_cyc.size() - r0 != 1 || take_cyc.size() - t0 != 1) begin
            bad++;
            $display("FAIL burst%0d got pops=%0d beats=%0d required 1 1", i, rinc_cyc.size() - r0, take_cyc.size() - t0);
         end
      end
   endtask

   task automatic test_midstream_reset();
      bit ok;
      reset_all();
      for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
      tick(1);
      rrst_n = 1'b0;
      #1;
      total++;
      if ({rinc, m_valid, m_data, pop_cnt, ovf_err} !== '0) begin
         bad++;
         $display("FAIL mid_reset_inflight got rinc=%0b valid=%0b data=%h pop=%0d required all 0", rinc, m_valid, m_data, pop_cnt);
      end
      release_reset();
      tick(8);
      rrst_n = 1'b0;
      #1;
      total++;
      if ({rinc, m_valid, m_data, pop_cnt, ovf_err} !== '0) begin
         bad++;
         $display("FAIL mid_reset_full got rinc=%0b valid=%0b data=%h pop=%0d required all 0", rinc, m_valid, m_data, pop_cnt);
      end
      release_reset();
      m_ready = 1'b1;
      wait_drain(30, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL mid_reset_drain got left=%0d required 0", exp_q.size());
      end
   endtask

   task automatic test_random();
      int budget;
      reset_all();
      for (int i = 0; i < 1000; i++) push(8'($urandom));
      budget = 5000;
      while (exp_q.size() > 0 && budget > 0) begin
         m_ready = 1'($urandom_range(0, 1));
         tick(1);
         budget--;
      end
      m_ready = 1'b0;
      total++;
      if (exp_q.size() != 0 || ovf_err !== 1'b0 || pop_cnt !== 16'd1000) begin
         bad++;
         $display("FAIL random got left=%0d ovf=%0b pop=%0d required 0 0 1000", exp_q.size(), ovf_err, pop_cnt);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick(2);
      test_reset();
      test_stream();
      test_backpressure();
      test_empty();
      test_bursts();
      test_midstream_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
